// File: rtl/noc_pkt_pkg.sv
// Packet layout, packet-type codes and requester FSM states shared by the PE-side NoC blocks.
// Packet: [19:18] type, [17:13] src, [12:8] dst, [7:0] payload.
package noc_pkt_pkg;

  localparam int NODE_W     = 5;
  localparam int PAYLOAD_W  = 8;
  localparam int TYPE_W     = 2;
  localparam int PKT_W      = TYPE_W + 2 * NODE_W + PAYLOAD_W;
  localparam int BUF_ADDR_W = 5;

  localparam int PAYLOAD_LSB = 0;
  localparam int DST_LSB     = PAYLOAD_LSB + PAYLOAD_W;
  localparam int SRC_LSB     = DST_LSB + NODE_W;
  localparam int TYPE_LSB    = SRC_LSB + NODE_W;

  localparam logic [TYPE_W-1:0] PKT_RESULT = 2'b00;
  localparam logic [TYPE_W-1:0] PKT_IFMAP  = 2'b01;
  localparam logic [TYPE_W-1:0] PKT_FILTER = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_F_REQ,
    ST_F_WAIT,
    ST_M_REQ,
    ST_M_WAIT,
    ST_DONE
  } req_state_e;

  function automatic logic [PKT_W-1:0] pack_pkt(input logic [NODE_W-1:0]    src,
                                                input logic [NODE_W-1:0]    dst,
                                                input logic [TYPE_W-1:0]    ptype,
                                                input logic [PAYLOAD_W-1:0] payload);
    logic [PKT_W-1:0] p;
    p = '0;
    p[TYPE_LSB +: TYPE_W]       = ptype;
    p[SRC_LSB +: NODE_W]        = src;
    p[DST_LSB +: NODE_W]        = dst;
    p[PAYLOAD_LSB +: PAYLOAD_W] = payload;
    return p;
  endfunction

  function automatic logic [TYPE_W-1:0] get_type(input logic [PKT_W-1:0] p);
    return p[TYPE_LSB +: TYPE_W];
  endfunction

  function automatic logic [NODE_W-1:0] get_src(input logic [PKT_W-1:0] p);
    return p[SRC_LSB +: NODE_W];
  endfunction

  function automatic logic [NODE_W-1:0] get_dst(input logic [PKT_W-1:0] p);
    return p[DST_LSB +: NODE_W];
  endfunction

  function automatic logic [PAYLOAD_W-1:0] get_payload(input logic [PKT_W-1:0] p);
    return p[PAYLOAD_LSB +: PAYLOAD_W];
  endfunction

endpackage

// File: rtl/pe_mem_requester_req_buffer.sv
// Small operand register file: one synchronous write port, one combinational read port.
// Out-of-range read addresses return zero.
module req_buffer
  import noc_pkt_pkg::*;
#(
  parameter int DEPTH  = 9,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [BUF_ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0]     wr_data,
  input  logic [BUF_ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0]     rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < DEPTH; k++) begin
        if (wr_addr == BUF_ADDR_W'(k)) mem[k] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (rd_addr == BUF_ADDR_W'(k)) rd_data = mem[k];
    end
  end

endmodule

// File: rtl/pe_mem_requester.sv
// PE-side memory requester: fetches filter and ifmap words one request at a time,
// buffers the replies locally, and forwards PE results to memory as write packets.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no load since reset; waits for start
// F_REQ   | filter read request on tx, held until tx_ready
// F_WAIT  | waiting for the filter reply for index idx
// M_REQ   | ifmap read request on tx, held until tx_ready
// M_WAIT  | waiting for the ifmap reply for index idx
// DONE    | all requested words captured; load_done high; accepts start
module pe_mem_requester
  import noc_pkt_pkg::*;
#(
  parameter int WIDTH            = 5,
  parameter int VALID_DATA_WIDTH = 8,
  parameter int DATA_WIDTH       = 20,
  parameter int MEM_INDEX        = 0,
  parameter int FILT_DEPTH       = 9,
  parameter int MAP_DEPTH        = 25
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [WIDTH-1:0]            my_index,
  input  logic                        start,
  input  logic [VALID_DATA_WIDTH-1:0] filt_base,
  input  logic [VALID_DATA_WIDTH-1:0] filt_cnt,
  input  logic [VALID_DATA_WIDTH-1:0] map_base,
  input  logic [VALID_DATA_WIDTH-1:0] map_cnt,
  output logic                        tx_valid,
  input  logic                        tx_ready,
  output logic [DATA_WIDTH-1:0]       tx_data,
  input  logic                        rx_valid,
  output logic                        rx_ready,
  input  logic [DATA_WIDTH-1:0]       rx_data,
  input  logic [BUF_ADDR_W-1:0]       buf_rd_addr,
  output logic [VALID_DATA_WIDTH-1:0] filt_rd_data,
  output logic [VALID_DATA_WIDTH-1:0] map_rd_data,
  output logic                        load_done,
  output logic                        busy,
  input  logic                        res_valid,
  output logic                        res_ready,
  input  logic [VALID_DATA_WIDTH-1:0] res_data,
  output logic                        err
);

  localparam logic [VALID_DATA_WIDTH-1:0] FILT_MAX = VALID_DATA_WIDTH'(FILT_DEPTH);
  localparam logic [VALID_DATA_WIDTH-1:0] MAP_MAX  = VALID_DATA_WIDTH'(MAP_DEPTH);
  localparam logic [WIDTH-1:0]            MEM_NODE = WIDTH'(MEM_INDEX);

  req_state_e state, state_nxt;

  logic [VALID_DATA_WIDTH-1:0] filt_base_q, filt_cnt_q, map_base_q, map_cnt_q;
  logic [BUF_ADDR_W-1:0]       idx;
  logic                        err_q;
  logic                        res_pend;
  logic                        res_en;
  logic [DATA_WIDTH-1:0]       res_pkt;

  logic [VALID_DATA_WIDTH-1:0] filt_cnt_clamp, map_cnt_clamp;
  logic [VALID_DATA_WIDTH-1:0] idx_inc;
  logic                        cnt_err;
  logic                        start_ok, in_req;
  logic                        rx_fire, good_f, good_m, rx_bad;
  logic                        last_f, last_m;
  logic                        unused_rx_src;

  assign filt_cnt_clamp = (filt_cnt > FILT_MAX) ? FILT_MAX : filt_cnt;
  assign map_cnt_clamp  = (map_cnt > MAP_MAX) ? MAP_MAX : map_cnt;
  assign cnt_err        = (filt_cnt > FILT_MAX) || (map_cnt > MAP_MAX);

  assign start_ok = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign in_req   = (state == ST_F_REQ) || (state == ST_M_REQ);
  assign idx_inc  = VALID_DATA_WIDTH'(idx) + 1'b1;
  assign last_f   = (idx_inc == filt_cnt_q);
  assign last_m   = (idx_inc == map_cnt_q);

  // A reply is good only if it matches the kind of word being waited for and is addressed to us.
  assign rx_fire = rx_valid && rx_ready;
  assign good_f  = rx_fire && (state == ST_F_WAIT) &&
                   (get_type(rx_data) == PKT_FILTER) && (get_dst(rx_data) == my_index);
  assign good_m  = rx_fire && (state == ST_M_WAIT) &&
                   (get_type(rx_data) == PKT_IFMAP) && (get_dst(rx_data) == my_index);
  assign rx_bad  = rx_fire && !good_f && !good_m;

  assign unused_rx_src = ^get_src(rx_data);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    tx_valid  = 1'b0;
    tx_data   = '0;
    rx_ready  = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          if (filt_cnt_clamp != '0)     state_nxt = ST_F_REQ;
          else if (map_cnt_clamp != '0) state_nxt = ST_M_REQ;
          else                          state_nxt = ST_DONE;
        end
      end
      ST_F_REQ: begin
        if (!res_pend) begin
          tx_valid = 1'b1;
          tx_data  = pack_pkt(my_index, MEM_NODE, PKT_FILTER,
                              filt_base_q + VALID_DATA_WIDTH'(idx));
          if (tx_ready) state_nxt = ST_F_WAIT;
        end
      end
      ST_F_WAIT: begin
        rx_ready = 1'b1;
        if (good_f) begin
          if (!last_f)              state_nxt = ST_F_REQ;
          else if (map_cnt_q != '0) state_nxt = ST_M_REQ;
          else                      state_nxt = ST_DONE;
        end
      end
      ST_M_REQ: begin
        if (!res_pend) begin
          tx_valid = 1'b1;
          tx_data  = pack_pkt(my_index, MEM_NODE, PKT_IFMAP,
                              map_base_q + VALID_DATA_WIDTH'(idx));
          if (tx_ready) state_nxt = ST_M_WAIT;
        end
      end
      ST_M_WAIT: begin
        rx_ready = 1'b1;
        if (good_m) state_nxt = last_m ? ST_DONE : ST_M_REQ;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // A pending result owns the tx channel ahead of any read request.
    if (res_pend) begin
      tx_valid = 1'b1;
      tx_data  = res_pkt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_base_q <= '0;
      filt_cnt_q  <= '0;
      map_base_q  <= '0;
      map_cnt_q   <= '0;
      idx         <= '0;
      err_q       <= 1'b0;
    end else begin
      if (start_ok) begin
        filt_base_q <= filt_base;
        filt_cnt_q  <= filt_cnt_clamp;
        map_base_q  <= map_base;
        map_cnt_q   <= map_cnt_clamp;
        idx         <= '0;
        err_q       <= cnt_err;
      end else begin
        if (good_f)      idx <= last_f ? '0 : idx + 1'b1;
        else if (good_m) idx <= last_m ? '0 : idx + 1'b1;
        if (rx_bad) err_q <= 1'b1;
      end
    end
  end

  // res_en keeps res_ready low while in reset and for the first cycle after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_en   <= 1'b0;
      res_pend <= 1'b0;
      res_pkt  <= '0;
    end else begin
      res_en <= 1'b1;
      if (res_valid && res_ready) begin
        res_pend <= 1'b1;
        res_pkt  <= pack_pkt(my_index, MEM_NODE, PKT_RESULT, res_data);
      end else if (res_pend && tx_ready) begin
        res_pend <= 1'b0;
      end
    end
  end

  assign res_ready = res_en && !in_req && !res_pend;
  assign load_done = (state == ST_DONE);
  assign busy      = (state != ST_IDLE) && (state != ST_DONE);
  assign err       = err_q;

  req_buffer #(.DEPTH(FILT_DEPTH), .DATA_W(VALID_DATA_WIDTH)) u_filt_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (good_f),
    .wr_addr (idx),
    .wr_data (get_payload(rx_data)),
    .rd_addr (buf_rd_addr),
    .rd_data (filt_rd_data)
  );

  req_buffer #(.DEPTH(MAP_DEPTH), .DATA_W(VALID_DATA_WIDTH)) u_map_buf (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (good_m),
    .wr_addr (idx),
    .wr_data (get_payload(rx_data)),
    .rd_addr (buf_rd_addr),
    .rd_data (map_rd_data)
  );

endmodule

// File: tb/tb_pe_mem_requester.sv
// Bench for pe_mem_requester: plays the memory node against a random memory image and
// checks request packets, buffered words, status flags and the result path.
module tb_pe_mem_requester;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  my_index;
  logic        start;
  logic [7:0]  filt_base, filt_cnt, map_base, map_cnt;
  logic        tx_valid, tx_ready;
  logic [19:0] tx_data;
  logic        rx_valid, rx_ready;
  logic [19:0] rx_data;
  logic [4:0]  buf_rd_addr;
  logic [7:0]  filt_rd_data, map_rd_data;
  logic        load_done, busy;
  logic        res_valid, res_ready;
  logic [7:0]  res_data;
  logic        err;

  int          vectors = 0;
  int          miscompares = 0;
  logic [7:0]  mem_img [256];
  bit          bad_seen;

  always #5 clk = ~clk;

  pe_mem_requester dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .my_index     (my_index),
    .start        (start),
    .filt_base    (filt_base),
    .filt_cnt     (filt_cnt),
    .map_base     (map_base),
    .map_cnt      (map_cnt),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_data      (tx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .rx_data      (rx_data),
    .buf_rd_addr  (buf_rd_addr),
    .filt_rd_data (filt_rd_data),
    .map_rd_data  (map_rd_data),
    .load_done    (load_done),
    .busy         (busy),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_data     (res_data),
    .err          (err)
  );

  // Packet value from its fields: type*2^18 + src*2^13 + dst*2^8 + payload.
  function automatic logic [19:0] mk(input int t, input int s, input int d, input int p);
    int v;
    v = t * 262144 + s * 8192 + d * 256 + (p % 256);
    return v[19:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic do_start(input int fb, input int fc, input int mb, input int mc);
    @(negedge clk);
    filt_base = 8'(fb); filt_cnt = 8'(fc); map_base = 8'(mb); map_cnt = 8'(mc);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Memory side of one word: accept the request, optionally stall, inject a result or a bad reply, then reply.
  task automatic serve(input int addr, input int rtype, input int hold, input bit bad, input bit res);
    logic [19:0] expv;
    int t;
    expv = mk(rtype, int'(my_index), 0, addr);
    t = 0;
    while (!tx_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("req_seen", {31'd0, tx_valid}, 32'd1);
    if (!tx_valid) return;
    check("req_pkt", {12'd0, tx_data}, {12'd0, expv});
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("req_hold_valid", {31'd0, tx_valid}, 32'd1);
      check("req_hold_data", {12'd0, tx_data}, {12'd0, expv});
    end
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("wait_no_tx", {31'd0, tx_valid}, 32'd0);
    if (res) begin
      res_valid = 1'b1;
      res_data  = 8'h55;
      check("res_ready_wait", {31'd0, res_ready}, 32'd1);
      @(negedge clk);
      res_valid = 1'b0;
      check("res_pkt_valid", {31'd0, tx_valid}, 32'd1);
      check("res_pkt", {12'd0, tx_data}, {12'd0, mk(0, int'(my_index), 0, 8'h55)});
      tx_ready = 1'b1;
      @(negedge clk);
      tx_ready = 1'b0;
      check("res_pkt_gone", {31'd0, tx_valid}, 32'd0);
    end
    check("rx_ready_wait", {31'd0, rx_ready}, 32'd1);
    if (bad) begin
      rx_valid = 1'b1;
      rx_data  = mk(rtype, 0, (my_index == 5'd6) ? 7 : 6, 8'hEE);
      @(negedge clk);
      rx_valid = 1'b0;
      bad_seen = 1'b1;
      check("bad_err", {31'd0, err}, 32'd1);
      check("bad_still_wait", {31'd0, rx_ready}, 32'd1);
      check("bad_no_tx", {31'd0, tx_valid}, 32'd0);
    end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = mk(rtype, 0, int'(my_index), int'(mem_img[addr]));
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // mode bit0: 5-cycle stall on first request; bit1: bad reply in first M_WAIT; bit2: result in first F_WAIT.
  task automatic run_load(input int fb, input int fc, input int mb, input int mc, input int mode);
    int  efc, emc;
    bit  exp_err;
    efc = (fc > 9) ? 9 : fc;
    emc = (mc > 25) ? 25 : mc;
    exp_err  = (fc > 9) || (mc > 25);
    bad_seen = 1'b0;
    do_start(fb, fc, mb, mc);
    check("start_err", {31'd0, err}, {31'd0, exp_err});
    for (int k = 0; k < efc; k++)
      serve((fb + k) % 256, 2, (mode[0] && k == 0) ? 5 : $urandom_range(0, 2), 1'b0,
            mode[2] && k == 0);
    for (int k = 0; k < emc; k++)
      serve((mb + k) % 256, 1, (mode[0] && efc == 0 && k == 0) ? 5 : $urandom_range(0, 2),
            mode[1] && k == 0, 1'b0);
    check("load_done", {31'd0, load_done}, 32'd1);
    check("busy_end", {31'd0, busy}, 32'd0);
    check("no_tx_end", {31'd0, tx_valid}, 32'd0);
    check("err_end", {31'd0, err}, {31'd0, exp_err | bad_seen});
    for (int k = 0; k < efc; k++) begin
      buf_rd_addr = 5'(k);
      #1;
      check("filt_buf", {24'd0, filt_rd_data}, {24'd0, mem_img[(fb + k) % 256]});
    end
    for (int k = 0; k < emc; k++) begin
      buf_rd_addr = 5'(k);
      #1;
      check("map_buf", {24'd0, map_rd_data}, {24'd0, mem_img[(mb + k) % 256]});
    end
  endtask

  initial begin
    int t;
    rst_n = 1'b0; my_index = 5'd4; start = 1'b0;
    filt_base = '0; filt_cnt = '0; map_base = '0; map_cnt = '0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0; buf_rd_addr = '0;
    res_valid = 1'b0; res_data = '0;
    for (int a = 0; a < 256; a++) mem_img[a] = 8'($urandom_range(0, 255));
    #12;
    check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check("rst_tx_data", {12'd0, tx_data}, 32'd0);
    check("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    check("rst_res_ready", {31'd0, res_ready}, 32'd0);
    check("rst_flags", {29'd0, load_done, busy, err}, 32'd0);
    check("rst_filt_buf", {24'd0, filt_rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    mem_img[10] = 8'd7; mem_img[11] = 8'd8; mem_img[12] = 8'd9;
    run_load(10, 3, 0, 0, 0);
    run_load($urandom_range(0, 255), 2, 0, 0, 1);
    run_load(30, 2, 40, 3, 2);
    run_load(50, 3, 60, 1, 4);
    run_load(254, 12, 0, 0, 0);
    run_load(0, 0, 0, 0, 0);
    run_load(100, 0, 200, 27, 0);

    // Reset while waiting for a filter reply.
    do_start(10, 3, 0, 0);
    t = 0;
    while (!tx_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("mid_req_seen", {31'd0, tx_valid}, 32'd1);
    tx_ready = 1'b1;
    @(negedge clk);
    tx_ready = 1'b0;
    check("mid_in_wait", {31'd0, rx_ready}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", {11'd0, tx_valid, tx_data}, 32'd0);
    check("mid_rst_flags", {27'd0, rx_ready, res_ready, load_done, busy, err}, 32'd0);
    check("mid_rst_buf", {24'd0, filt_rd_data}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_load(10, 3, 20, 2, 0);

    for (int n = 0; n < 6; n++) begin
      my_index = 5'($urandom_range(1, 31));
      run_load($urandom_range(0, 255), $urandom_range(0, 11), $urandom_range(0, 255),
               $urandom_range(0, 27), $urandom_range(0, 7));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
